// File: rtl/seq_detector_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detector_param
//  Description : Parametrised serial bit-pattern detector. One serial bit is
//                sampled on each rising Clk edge where in_valid=1. The most
//                recent PAT_W bits are compared against PATTERN, and a
//                registered one-cycle pulse is raised on a match.
//                Overlapping or non-overlapping detection is chosen at run
//                time with the overlap input.
//                An optional saturating match counter can be built in.
//
//  Optional    : SEQ_DET_MATCH_CNT_EN
//                  defined   -> match_cnt is a saturating counter of matches,
//                               and cnt_clr clears it synchronously.
//                  undefined -> match_cnt is tied to 0, no counter flops are
//                               built, and cnt_clr is ignored.
//
//  Parameters  : PAT_W   - pattern length in bits (2..16)
//                PATTERN - target sequence, MSB = oldest bit, LSB = newest
//                CNT_W   - match counter width
//
//  Ports       : Clk       in   1      system clock, rising edge
//                Clr       in   1      asynchronous active-high reset
//                in_valid  in   1      qualifies in
//                in        in   1      serial data bit
//                overlap   in   1      1 = overlapping, 0 = non-overlapping
//                cnt_clr   in   1      synchronous clear of match_cnt
//                out       out  1      registered match pulse
//                match_cnt out  CNT_W  matches since reset or cnt_clr
//
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detector_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter int               CNT_W   = 8
) (
    input  logic             Clk,
    input  logic             Clr,
    input  logic             in_valid,
    input  logic             in,
    input  logic             overlap,
    input  logic             cnt_clr,
    output logic             out,
    output logic [CNT_W-1:0] match_cnt
);

    // fill counts from 0 up to PAT_W, so it needs clog2(PAT_W+1) bits.
    localparam int                  c_FILL_W = $clog2(PAT_W + 1);
    localparam logic [c_FILL_W-1:0] c_FULL   = c_FILL_W'(PAT_W);

    logic [PAT_W-1:0]    r_hist;
    logic [c_FILL_W-1:0] r_fill;
    logic                r_out;

    logic [PAT_W-1:0]    w_next_hist;
    logic [c_FILL_W-1:0] w_next_fill;
    logic                w_match;

    // The match is judged on the window that will exist after this edge.
    // This lets the pulse appear exactly one cycle after the completing bit.
    assign w_next_hist = {r_hist[PAT_W-2:0], in};
    assign w_next_fill = (r_fill == c_FULL) ? c_FULL : r_fill + 1'b1;

    // The fill gate stops reset zeros, or bits already consumed by a
    // non-overlapping match, from being treated as real history.
    assign w_match = in_valid && (w_next_hist == PATTERN) && (w_next_fill == c_FULL);

    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_hist <= '0;
            r_fill <= '0;
            r_out  <= 1'b0;
        end else begin
            r_out <= w_match;
            if (in_valid) begin
                r_hist <= w_next_hist;
                // In non-overlapping mode, a match consumes the whole window.
                // The history still shifts, but the next match needs PAT_W
                // new bits because fill restarts at 0.
                if (w_match && !overlap) begin
                    r_fill <= '0;
                end else begin
                    r_fill <= w_next_fill;
                end
            end
        end
    end

    assign out = r_out;

`ifdef SEQ_DET_MATCH_CNT_EN
    logic [CNT_W-1:0] r_cnt;

    // cnt_clr has priority, so a match on the same edge is not counted.
    // The counter saturates at all-ones and never wraps.
    always_ff @(posedge Clk or posedge Clr) begin
        if (Clr) begin
            r_cnt <= '0;
        end else if (cnt_clr) begin
            r_cnt <= '0;
        end else if (w_match && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign match_cnt = r_cnt;
`else
    // No counter is built in this configuration. cnt_clr is deliberately
    // left without effect.
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign match_cnt        = '0;
`endif

endmodule
`default_nettype wire
